// File: rtl/rv_dbus_arb.sv
// Two-master arbiter for the dpram read/write port: same-cycle grant, 1-cycle read return.
// Optional round-robin tie policy enabled by defining RV_DBUS_ARB_RR_EN (default: m0 fixed priority).
module rv_dbus_arb #(
    parameter int AW      = 32,
    parameter int MAXWAIT = 15
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_m0_adr,
    input  logic          i_m0_re,
    input  logic [3:0]    i_m0_we,
    input  logic [31:0]   i_m0_dw,
    output logic [31:0]   o_m0_dr,
    output logic          o_m0_rdy,
    input  logic [AW-1:0] i_m1_adr,
    input  logic          i_m1_re,
    input  logic [3:0]    i_m1_we,
    input  logic [31:0]   i_m1_dw,
    output logic [31:0]   o_m1_dr,
    output logic          o_m1_rdy,
    input  logic          i_m1_lock,
    output logic [AW-1:0] o_s_adr,
    output logic          o_s_re,
    output logic [3:0]    o_s_we,
    output logic [31:0]   o_s_dw,
    input  logic [31:0]   i_s_dr
);

    localparam int CLW = $clog2(MAXWAIT + 1);
    localparam int CW  = (CLW > 4) ? CLW : 4;
    localparam logic [CW-1:0] WMAX = CW'(MAXWAIT);

    typedef enum logic {LAST_M0 = 1'b0, LAST_M1 = 1'b1} last_t;

    last_t         r_last;
    logic [1:0]    r_rsel;
    logic [CW-1:0] r_wcnt [2];

    logic [1:0]    w_req;
    logic [1:0]    w_re;
    logic [1:0]    w_sat;
    logic [1:0]    w_gnt;
    logic          w_pick1;

    assign w_req    = {i_m1_re | (|i_m1_we), i_m0_re | (|i_m0_we)};
    assign w_re     = {i_m1_re, i_m0_re};
    assign w_sat[0] = (r_wcnt[0] == WMAX);
    assign w_sat[1] = (r_wcnt[1] == WMAX);

    // Tie resolution: starvation beats lock, lock beats the tie policy.
    always_comb begin
        w_pick1 = 1'b0;
        if (w_sat == 2'b11)
            w_pick1 = (r_last == LAST_M0);
        else if (w_sat[0])
            w_pick1 = 1'b0;
        else if (w_sat[1])
            w_pick1 = 1'b1;
        else if (i_m1_lock && r_last == LAST_M1)
            w_pick1 = 1'b1;
        else begin
`ifdef RV_DBUS_ARB_RR_EN
            w_pick1 = (r_last == LAST_M0);
`else
            w_pick1 = 1'b0;
`endif
        end
    end

    always_comb begin
        w_gnt = w_req;
        if (w_req == 2'b11)
            w_gnt = w_pick1 ? 2'b10 : 2'b01;
        if (i_reset)
            w_gnt = 2'b00;
    end

    always_comb begin
        o_s_adr = '0;
        o_s_re  = 1'b0;
        o_s_we  = 4'b0000;
        o_s_dw  = '0;
        if (w_gnt[0]) begin
            o_s_adr = i_m0_adr;
            o_s_re  = i_m0_re;
            o_s_we  = i_m0_we;
            o_s_dw  = i_m0_dw;
        end else if (w_gnt[1]) begin
            o_s_adr = i_m1_adr;
            o_s_re  = i_m1_re;
            o_s_we  = i_m1_we;
            o_s_dw  = i_m1_dw;
        end
    end

    assign o_m0_rdy = ~i_reset & (~w_req[0] | w_gnt[0]);
    assign o_m1_rdy = ~i_reset & (~w_req[1] | w_gnt[1]);

    // Read data from a read in flight is suppressed while reset is high.
    assign o_m0_dr = (r_rsel[0] && !i_reset) ? i_s_dr : 32'h0;
    assign o_m1_dr = (r_rsel[1] && !i_reset) ? i_s_dr : 32'h0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsel <= 2'b00;
            r_last <= LAST_M1;
            for (int i = 0; i < 2; i++)
                r_wcnt[i] <= '0;
        end else begin
            r_rsel <= w_gnt & w_re;
            if (w_gnt[0])
                r_last <= LAST_M0;
            else if (w_gnt[1])
                r_last <= LAST_M1;
            for (int i = 0; i < 2; i++) begin
                if (!w_req[i] || w_gnt[i])
                    r_wcnt[i] <= '0;
                else if (r_wcnt[i] != WMAX)
                    r_wcnt[i] <= r_wcnt[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv_dbus_arb.sv
// Bench for rv_dbus_arb: directed scenarios plus random traffic against a rule-level model.
module tb_rv_dbus_arb;
    localparam int AW      = 32;
    localparam int MAXWAIT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic          m0_re, m1_re, s_re, m1_lock;
    logic [3:0]    m0_we, m1_we, s_we;
    logic [31:0]   m0_dw, m1_dw, s_dw, s_dr, m0_dr, m1_dr;
    logic          m0_rdy, m1_rdy;

    int n_chk  = 0;
    int n_fail = 0;

    // reference state: wait counts, last granted master, master with a read in flight
    int mw[2];
    int mlast;
    int mpend;
    int gcur;
    logic obs_rdy0, obs_rdy1;
    logic [31:0] obs_dr1;

    rv_dbus_arb #(.AW(AW), .MAXWAIT(MAXWAIT)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_adr(m0_adr), .i_m0_re(m0_re), .i_m0_we(m0_we), .i_m0_dw(m0_dw),
        .o_m0_dr(m0_dr), .o_m0_rdy(m0_rdy),
        .i_m1_adr(m1_adr), .i_m1_re(m1_re), .i_m1_we(m1_we), .i_m1_dw(m1_dw),
        .o_m1_dr(m1_dr), .o_m1_rdy(m1_rdy), .i_m1_lock(m1_lock),
        .o_s_adr(s_adr), .o_s_re(s_re), .o_s_we(s_we), .o_s_dw(s_dw), .i_s_dr(s_dr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input bit r0, input bit r1, input bit lock);
        bit s0, s1;
        if (!r0 && !r1) return -1;
        if (r0 && !r1) return 0;
        if (!r0 && r1) return 1;
        s0 = (mw[0] >= MAXWAIT);
        s1 = (mw[1] >= MAXWAIT);
        if (s0 && s1) return 1 - mlast;
        if (s0) return 0;
        if (s1) return 1;
        if (lock && mlast == 1) return 1;
`ifdef RV_DBUS_ARB_RR_EN
        return 1 - mlast;
`else
        return 0;
`endif
    endfunction

    task automatic idle();
        m0_adr = '0; m0_re = 0; m0_we = 0; m0_dw = '0;
        m1_adr = '0; m1_re = 0; m1_we = 0; m1_dw = '0;
        m1_lock = 0;
    endtask

    // Inputs are driven just after a rising edge; check mid-cycle, then advance the model.
    task automatic tick();
        bit r0, r1;
        logic [AW-1:0] ea;
        logic          ere;
        logic [3:0]    ewe;
        logic [31:0]   edw, ed0, ed1;
        r0 = m0_re | (|m0_we);
        r1 = m1_re | (|m1_we);
        #2;
        gcur = rst ? -1 : pick(r0, r1, m1_lock);
        ea = '0; ere = 0; ewe = 0; edw = '0;
        if (gcur == 0) begin ea = m0_adr; ere = m0_re; ewe = m0_we; edw = m0_dw; end
        if (gcur == 1) begin ea = m1_adr; ere = m1_re; ewe = m1_we; edw = m1_dw; end
        ed0 = (!rst && mpend == 0) ? s_dr : 32'h0;
        ed1 = (!rst && mpend == 1) ? s_dr : 32'h0;
        chk("m0_rdy", 64'(m0_rdy), rst ? 64'd0 : 64'(!r0 || gcur == 0));
        chk("m1_rdy", 64'(m1_rdy), rst ? 64'd0 : 64'(!r1 || gcur == 1));
        chk("s_adr", 64'(s_adr), 64'(ea));
        chk("s_re", 64'(s_re), 64'(ere));
        chk("s_we", 64'(s_we), 64'(ewe));
        chk("s_dw", 64'(s_dw), 64'(edw));
        chk("m0_dr", 64'(m0_dr), 64'(ed0));
        chk("m1_dr", 64'(m1_dr), 64'(ed1));
        obs_rdy0 = m0_rdy;
        obs_rdy1 = m1_rdy;
        obs_dr1  = m1_dr;
        @(posedge clk);
        if (rst) begin
            mw[0] = 0; mw[1] = 0; mlast = 1; mpend = -1;
        end else begin
            mpend = (gcur == 0 && m0_re) ? 0 : (gcur == 1 && m1_re) ? 1 : -1;
            mw[0] = (r0 && gcur != 0) ? ((mw[0] + 1 > MAXWAIT) ? MAXWAIT : mw[0] + 1) : 0;
            mw[1] = (r1 && gcur != 1) ? ((mw[1] + 1 > MAXWAIT) ? MAXWAIT : mw[1] + 1) : 0;
            if (gcur >= 0) mlast = gcur;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        int first;
        int hold0, hold1;
        mw[0] = 0; mw[1] = 0; mlast = 1; mpend = -1; gcur = -1;
        idle(); rst = 1; s_dr = 32'h0;
        @(posedge clk); #1;

        // reset with active requests: everything must read zero
        m0_re = 1; m1_we = 4'hF; s_dr = 32'h1234_5678;
        tick(); tick();
        rst = 0; idle();

        // 1: lone m0 read, data returns next cycle to m0 only
        m0_re = 1; m0_adr = 32'h100; tick();
        chk("t1_rdy", 64'(obs_rdy0), 64'd1);
        idle(); s_dr = 32'hDEAD_BEEF; tick();

        // 2: m0 write vs m1 read
        m0_we = 4'b0011; m0_adr = 32'h40; m0_dw = 32'hCAFE_0001;
        m1_re = 1; m1_adr = 32'h40; tick();
        chk("t2_m1_stall", 64'(obs_rdy1), 64'd0);
        m0_we = 0; tick();
        chk("t2_m1_gnt", 64'(obs_rdy1), 64'd1);
        idle(); s_dr = 32'h0BAD_F00D; tick();

        // 3: both requesting continuously from reset
        do_reset();
        m0_re = 1; m0_adr = 32'h8; m1_re = 1; m1_adr = 32'hC;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            s_dr = $urandom;
            tick();
            if (first == 0 && obs_rdy1) first = k;
            else if (first != 0 && k == first + 1) chk("t3_after", 64'(obs_rdy0), 64'd1);
        end
`ifdef RV_DBUS_ARB_RR_EN
        chk("t3_first_m1", 64'(first), 64'd2);
`else
        chk("t3_first_m1", 64'(first), 64'd16);
`endif
        idle();

        // 5: m1 holds lock, m0 forced in after MAXWAIT stall cycles
        do_reset();
        m1_re = 1; m1_lock = 1; m1_adr = 32'h20; tick();
        m0_re = 1; m0_adr = 32'h24;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            s_dr = $urandom;
            tick();
            if (first == 0 && obs_rdy0) first = k;
        end
        chk("t5_first_m0", 64'(first), 64'd16);
        idle();

        // 6: reset right after an accepted m1 read
        do_reset();
        m1_re = 1; m1_adr = 32'h30; tick();
        s_dr = 32'hFEED_FACE; rst = 1; tick();
        chk("t6_dr_in_reset", 64'(obs_dr1), 64'd0);
        rst = 0; m0_re = 1; tick();
        chk("t6_tie_m0", 64'(obs_rdy0), 64'd1);
        chk("t6_tie_m1", 64'(obs_rdy1), 64'd0);
        idle();

        // random traffic; a stalled master keeps its request unchanged
        hold0 = 0; hold1 = 0;
        for (int k = 0; k < 400; k++) begin
            if (!hold0) begin
                m0_re = 0; m0_we = 0;
                if ($urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 2))
                        0: m0_re = 1;
                        1: m0_we = 4'($urandom_range(1, 15));
                        default: begin m0_re = 1; m0_we = 4'($urandom_range(1, 15)); end
                    endcase
                end
                m0_adr = $urandom & 32'hFFFF_FFFC; m0_dw = $urandom;
            end
            if (!hold1) begin
                m1_re = 0; m1_we = 0;
                if ($urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 2))
                        0: m1_re = 1;
                        1: m1_we = 4'($urandom_range(1, 15));
                        default: begin m1_re = 1; m1_we = 4'($urandom_range(1, 15)); end
                    endcase
                end
                m1_adr = $urandom & 32'hFFFF_FFFC; m1_dw = $urandom;
            end
            m1_lock = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 63) == 0);
            s_dr = $urandom;
            tick();
            hold0 = (!rst && (m0_re || m0_we != 0) && gcur != 0);
            hold1 = (!rst && (m1_re || m1_we != 0) && gcur != 1);
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
